// File: rtl/clct_key_busy_gen_pkg.sv
// Shared key/pattern geometry for the CLCT sorter loop, plus busy-blanking widths.
package clct_key_busy_gen_pkg;
  localparam int MXKEY  = 32;
  localparam int MXKEYB = 5;
  localparam int MXPATB = 7;
  localparam int MXDT   = 4;
  localparam int MXSPR  = 3;

  // Layer-hit count lives in the top three bits of the pattern word.
  localparam int HIT_HI = 6;
  localparam int HIT_LO = 4;

  function automatic logic [HIT_HI-HIT_LO:0] pat_hits(input logic [MXPATB-1:0] pat);
    return pat[HIT_HI:HIT_LO];
  endfunction
endpackage

// File: rtl/clct_key_busy_cnt.sv
// One key's dead-time down-counter; busy while nonzero.
module clct_key_busy_cnt
  import clct_key_busy_gen_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_flush,
  input  logic            i_load,
  input  logic [MXDT-1:0] i_load_val,
  output logic            o_busy,
  output logic            o_busy_nxt
);
  logic [MXDT-1:0] r_cnt;
  logic [MXDT-1:0] w_cnt_nxt;

  // Flush beats load so a flushing cycle can never restart blanking.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_flush)           w_cnt_nxt = '0;
    else if (i_load)       w_cnt_nxt = i_load_val;
    else if (r_cnt != '0)  w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end

  assign o_busy     = (r_cnt != '0);
  assign o_busy_nxt = (w_cnt_nxt != '0);
endmodule

// File: rtl/clct_key_busy_gen.sv
// Per-key busy mask for the best-1-of-32 sorter: blanks the winner and its neighbours.
module clct_key_busy_gen
  import clct_key_busy_gen_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              hit_vld,
  input  logic [MXKEYB-1:0] hit_key,
  input  logic [MXPATB-1:0] hit_pat,
  input  logic              hit_bsy,
  input  logic [2:0]        hit_thresh,
  input  logic [MXSPR-1:0]  spread,
  input  logic [MXDT-1:0]   dead_time,
  input  logic              flush,
  output logic [MXKEY-1:0]  bsy,
  output logic [5:0]        bsy_cnt,
  output logic              accept
);
  logic              w_accept;
  logic [MXKEYB:0]   w_key_x, w_spr_x, w_lo, w_hi_raw, w_hi;
  logic [MXKEY-1:0]  w_load;
  logic [MXKEY-1:0]  w_bsy_nxt;
  logic [5:0]        w_pop;

  assign w_accept = hit_vld && !hit_bsy && (pat_hits(hit_pat) >= hit_thresh)
                 && (dead_time != '0) && !flush;

  // One extra bit so key+spread cannot wrap past 31 back into low keys.
  assign w_key_x  = {1'b0, hit_key};
  assign w_spr_x  = {{(MXKEYB+1-MXSPR){1'b0}}, spread};
  assign w_lo     = (w_key_x >= w_spr_x) ? (w_key_x - w_spr_x) : '0;
  assign w_hi_raw = w_key_x + w_spr_x;
  assign w_hi     = (w_hi_raw > (MXKEYB+1)'(MXKEY-1)) ? (MXKEYB+1)'(MXKEY-1) : w_hi_raw;

  for (genvar k = 0; k < MXKEY; k++) begin : g_key
    localparam logic [MXKEYB:0] KX = (MXKEYB+1)'(k);
    assign w_load[k] = w_accept && (KX >= w_lo) && (KX <= w_hi);

    clct_key_busy_cnt u_cnt (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_flush    (flush),
      .i_load     (w_load[k]),
      .i_load_val (dead_time),
      .o_busy     (bsy[k]),
      .o_busy_nxt (w_bsy_nxt[k])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < MXKEY; k++) w_pop = w_pop + 6'(w_bsy_nxt[k]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bsy_cnt <= '0;
      accept  <= 1'b0;
    end else begin
      bsy_cnt <= w_pop;
      accept  <= w_accept;
    end
  end
endmodule
